// File: rtl/sum_rest_serial.sv
// rtl/sum_rest_serial.sv - Slice-serial adder/subtractor with valid/ready handshake; optional SUM_REST_SAT_EN saturates on overflow
module sum_rest_serial #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Resta,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] SumaRest,
    output logic             c_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);
    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] a_lat, b_lat, result;
    logic [CW-1:0]    cnt;
    logic             carry, cout_r, ovf_r, res_seen;
    logic             accept, last;
    logic [SLICE-1:0] a_sl, b_sl, s_sl;
    logic             cy, msb_cin, ovf_n;

    // Slice adder: one SLICE-wide add per clock, carry chained through the carry register
    assign a_sl = a_lat[cnt*SLICE +: SLICE];
    assign b_sl = b_lat[cnt*SLICE +: SLICE];
    assign {cy, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry};
    // Carry into the MSB recovered from its sum bit, so any SLICE (including 1) works
    assign msb_cin = a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ s_sl[SLICE-1];
    assign ovf_n   = msb_cin ^ cy;
    assign last    = (cnt == LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    accept  = 1'b1;
                    state_n = CALC;
                end
            end
            CALC: begin
                if (last) state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Operand capture, slice accumulation and flag capture on the final slice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_lat    <= '0;
            b_lat    <= '0;
            result   <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
            res_seen <= 1'b0;
        end else if (accept) begin
            a_lat <= A;
            b_lat <= Resta ? ~B : B;
            carry <= Resta;
            cnt   <= '0;
        end else if (state == CALC) begin
            result[cnt*SLICE +: SLICE] <= s_sl;
            carry <= cy;
            cnt   <= cnt + 1'b1;
            if (last) begin
                cout_r   <= cy;
                ovf_r    <= ovf_n;
                res_seen <= 1'b1;
`ifdef SUM_REST_SAT_EN
                if (ovf_n)
                    result <= a_lat[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                             : {1'b0, {(WIDTH-1){1'b1}}};
`endif
            end
        end
    end

    assign SumaRest = result;
    assign c_out    = cout_r;
    assign overflow = ovf_r;
    // res_seen keeps zero low after reset, before any result exists
    assign zero     = res_seen && (result == '0);
    assign negative = result[WIDTH-1];

endmodule

// File: doc/sum_rest_serial.md
Name: sum_rest_serial

Overview:
- Parametrised multi-cycle adder/subtractor, the successor to the 4-bit combinational add/sub unit.
- Processes WIDTH-bit operands SLICE bits per clock, with the carry held in a register between slices.
- Uses a valid/ready handshake on both sides and produces signed/unsigned status flags.
- Sits in the ALU datapath where wide operands must be handled with minimal adder area.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of SLICE and ≥ SLICE.
- SLICE, 4, bits added per clock cycle (the width of the slice adder).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept an operation.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Resta  input  1  0 = A+B, 1 = A−B (A + ~B + 1).
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- SumaRest  output  WIDTH  result.
- c_out  output  1  carry out of MSB; for subtraction, 1 = no borrow (A ≥ B unsigned).
- overflow  output  1  signed two's-complement overflow.
- zero  output  1  SumaRest == 0.
- negative  output  1  SumaRest[WIDTH-1].

Behaviour:
- N = WIDTH/SLICE. Slice counter is $clog2(N) bits wide; minimum 1 bit.
- States:
  - IDLE: in_ready=1.
  - CALC: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Reset (async, rst_n=0): state=IDLE, counter=0, carry register=0. SumaRest, c_out, overflow, zero, negative all 0; out_valid=0; in_ready=1 once rst_n is released.
- IDLE→CALC on the edge where in_valid && in_ready:
  - Latch A, ~B if Resta else B, and Resta.
  - Carry register := Resta.
  - Counter := 0.
- Inputs are sampled only at acceptance. Later changes on A/B/Resta have no effect.
- CALC, each edge:
  - Slice i = counter adds A_lat[i*SLICE +: SLICE] + B_lat[same] + carry.
  - Writes the sum slice into the result register; the slice carry-out goes to the carry register.
  - counter++.
  - On the edge processing slice N−1: capture c_out = final carry and overflow = carry into MSB XOR carry out of MSB; go to DONE.
- Latency: out_valid rises exactly N cycles after the acceptance edge (4 cycles with defaults).
- DONE: outputs are stable while out_valid=1 && out_ready=0, held indefinitely. On the edge with out_ready=1, go to IDLE and clear out_valid.
- out_ready is ignored outside DONE.
- No new operation is accepted in the DONE→IDLE cycle. Throughput is one operation per N+2 cycles minimum.
- zero and negative are combinational from the result register, qualified only by the consumer reading them when out_valid=1.
- SumaRest keeps its last value in IDLE and CALC. Partial slices are visible during CALC; consumers must not sample them.
- rst_n asserted mid-CALC or in DONE: the operation is aborted, all state is reset, and no out_valid is produced.
- in_valid with out_ready simultaneously high in DONE: in_valid is ignored (in_ready=0).

Optional Feature:
- Macro: SUM_REST_SAT_EN.
- Defined: when overflow=1, the result written on entry to DONE is clamped:
  - Positive overflow (operand A MSB = 0) → 0 followed by all 1s (0x7FFF for WIDTH=16).
  - Negative overflow → 1 followed by all 0s (0x8000).
  - overflow flag still reports 1; c_out is unchanged; zero and negative reflect the clamped value.
  - Clamping adds no cycle.
- Undefined: result wraps modulo 2^WIDTH and no clamp logic is synthesised.

Test Plan (WIDTH=16, SLICE=4):
- Add 0x00FF + 0x0001, out_ready=1 → out_valid 4 cycles after accept; SumaRest=0x0100, c_out=0, overflow=0, zero=0, negative=0.
- Add 0xFFFF + 0x0001 → SumaRest=0x0000, c_out=1, zero=1, overflow=0.
- Add 0x7FFF + 0x0001 → overflow=1, negative=1; SumaRest=0x8000 (0x7FFF with SUM_REST_SAT_EN).
- Sub 0x0003 − 0x0005 → SumaRest=0xFFFE, c_out=0, negative=1, overflow=0. Sub 0x0005 − 0x0003 → 0x0002, c_out=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → outputs stable, in_ready=0, in_valid pulses ignored. Raise out_ready → IDLE next edge, in_ready=1.
- Reset mid-CALC: pull rst_n low 2 cycles after accept → out_valid=0, all outputs 0 immediately. Release → in_ready=1; a following 0x1234 + 0x1111 gives 0x2345.
